// File: rtl/addern_operand_loader_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : addern_pkg                                                       |
// | Purpose  : Shared types and helpers for the Addern operand loader.          |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

package addern_pkg;

  localparam int ADDERN_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    COMPUTE = 2'd2,
    SHOW    = 2'd3
  } loader_state_t;

  // Two's-complement overflow from sign bits only: like-signed operands
  // whose sum comes back with the opposite sign.
  function automatic logic add_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addern_operand_loader_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : addern_loader_if                                                 |
// | Purpose  : Board I/O and Addern-side signals of the operand loader.         |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface addern_loader_if #(
  parameter int N = addern_pkg::ADDERN_N_DEFAULT
);
  logic         Load_n;
  logic [N-1:0] Data;
  logic         Cin_sw;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] S;
  logic         Cout;
  logic [N:0]   Result;
  logic         Valid;
  logic         Overflow;
  logic [1:0]   State;

  // Board and adder side: drives keys, switches and the adder outputs.
  modport master (
    output Load_n, Data, Cin_sw, S, Cout,
    input  A, B, Cin, Result, Valid, Overflow, State
  );

  // Loader side.
  modport slave (
    input  Load_n, Data, Cin_sw, S, Cout,
    output A, B, Cin, Result, Valid, Overflow, State
  );

endinterface

`default_nettype wire

// File: rtl/addern_operand_loader_key_edge_detect.sv
// +-----------------------------------------------------------------------------+
// | Module   : key_edge_detect                                                  |
// | Purpose  : Synchronizes an active-low key and emits a one-clock press pulse |
// |            on each falling edge. Optional debounce: ADDERN_LOADER_DEBOUNCE_EN|
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module key_edge_detect #(
  parameter int DB_CYCLES = 500000
) (
  input  wire logic CLOCK_50,
  input  wire logic Resetn,
  input  wire logic key_n,
  output logic      press
);

  logic sync1;
  logic sync2;
  logic level;
  logic hist;

  if (DB_CYCLES < 1) begin : g_db_check
    $error("key_edge_detect: DB_CYCLES must be at least 1");
  end

  // Flops reset high so a released button is the idle level.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

`ifdef ADDERN_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] db_cnt;
  logic          db_level;

  // The debounced level follows sync2 only after DB_CYCLES consecutive
  // clocks of disagreement; any return to the old level restarts the count.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      db_cnt   <= '0;
      db_level <= 1'b1;
    end else if (sync2 != db_level) begin
      if (db_cnt == CW'(DB_CYCLES - 1)) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      hist  <= 1'b1;
      press <= 1'b0;
    end else begin
      hist  <= level;
      press <= hist & ~level;
    end
  end

endmodule

`default_nettype wire

// File: rtl/addern_operand_loader.sv
// +-----------------------------------------------------------------------------+
// | Module   : addern_operand_loader                                            |
// | Purpose  : Captures A then B/Cin from switches on key presses, holds them   |
// |            on Addern and registers {Cout,S}. Option: ADDERN_LOADER_DEBOUNCE_EN|
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module addern_operand_loader
  import addern_pkg::*;
#(
  parameter int N         = ADDERN_N_DEFAULT,
  parameter int DB_CYCLES = 500000
) (
  input wire logic       CLOCK_50,
  input wire logic       Resetn,
  addern_loader_if.slave bus
);

  loader_state_t state;
  loader_state_t state_next;

  logic         press;
  logic         capture_a;
  logic         capture_b;
  logic         compute;

  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_cin;
  logic [N:0]   result_q;
  logic         valid_q;
  logic         overflow_q;

  key_edge_detect #(
    .DB_CYCLES (DB_CYCLES)
  ) u_key_edge_detect (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .key_n    (bus.Load_n),
    .press    (press)
  );

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state <= WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // COMPUTE always lasts one cycle, so a press landing there is dropped.
  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_A:  if (press) state_next = WAIT_B;
      WAIT_B:  if (press) state_next = COMPUTE;
      COMPUTE: state_next = SHOW;
      SHOW:    if (press) state_next = WAIT_B;
      default: state_next = WAIT_A;
    endcase
  end

  // SHOW reuses the WAIT_A capture so a new sum needs no extra press.
  always_comb begin
    capture_a = 1'b0;
    capture_b = 1'b0;
    compute   = 1'b0;
    unique case (state)
      WAIT_A:  capture_a = press;
      WAIT_B:  capture_b = press;
      COMPUTE: compute   = 1'b1;
      SHOW:    capture_a = press;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (capture_a) begin
        op_a    <= bus.Data;
        valid_q <= 1'b0;
      end
      if (capture_b) begin
        op_b   <= bus.Data;
        op_cin <= bus.Cin_sw;
      end
      if (compute) begin
        result_q   <= {bus.Cout, bus.S};
        valid_q    <= 1'b1;
        overflow_q <= add_overflow(op_a[N-1], op_b[N-1], bus.S[N-1]);
      end
    end
  end

  assign bus.A        = op_a;
  assign bus.B        = op_b;
  assign bus.Cin      = op_cin;
  assign bus.Result   = result_q;
  assign bus.Valid    = valid_q;
  assign bus.Overflow = overflow_q;
  assign bus.State    = state;

endmodule

`default_nettype wire

// File: tb/tb_addern_operand_loader.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_addern_operand_loader                                         |
// | Purpose  : Randomized scoreboard bench for addern_operand_loader (N=4).     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_addern_operand_loader;

  localparam int N   = 4;
  localparam int DB  = 8;
`ifdef ADDERN_LOADER_DEBOUNCE_EN
  localparam int LAT = DB + 4;
`else
  localparam int LAT = 4;
`endif
  localparam int LIM = LAT + 20;

  typedef struct {
    logic [N:0] res;
    logic       ovf;
  } exp_t;

  logic clk;
  logic Resetn;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic prev_valid;
  logic [N-1:0] model_a;
  logic [N:0]   last_res;

  addern_loader_if #(.N(N)) bus ();

  addern_operand_loader #(
    .N         (N),
    .DB_CYCLES (DB)
  ) dut (
    .CLOCK_50 (clk),
    .Resetn   (Resetn),
    .bus      (bus)
  );

  // Combinational Addern stand-in.
  assign {bus.Cout, bus.S} = {1'b0, bus.A} + {1'b0, bus.B} + {{N{1'b0}}, bus.Cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the captured operands.
  function automatic exp_t model_add(input int a, input int b, input int c);
    exp_t e;
    int   sa, sb_, ss;
    int   sum;
    sum   = a + b + c;
    sa    = (a >= 8) ? a - 16 : a;
    sb_   = (b >= 8) ? b - 16 : b;
    ss    = sa + sb_ + c;
    e.res = sum[N:0];
    e.ovf = (ss > 7) || (ss < -8);
    return e;
  endfunction

  // Scoreboard monitor: compares on every rising Valid.
  always @(negedge clk) begin
    if (Resetn && bus.Valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", 32'(bus.Result), 32'(e.res));
        chk("sb_overflow", 32'(bus.Overflow), 32'(e.ovf));
      end
    end
    prev_valid <= Resetn ? bus.Valid : 1'b0;
  end

  task automatic press_start(input logic [N-1:0] d, input logic c, output int lat);
    logic [1:0] s0;
    bus.Data   = d;
    bus.Cin_sw = c;
    bus.Load_n = 1'b0;
    s0  = bus.State;
    lat = 0;
    while (bus.State == s0 && lat < LIM) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_key();
    bus.Load_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic stage_a(input logic [N-1:0] a);
    int lat;
    press_start(a, 1'b0, lat);
    chk("lat_a", 32'(lat), 32'(LAT));
    chk("state_after_a", 32'(bus.State), 32'd1);
    chk("a_captured", 32'(bus.A), 32'(a));
    chk("valid_cleared", 32'(bus.Valid), 32'd0);
    model_a = a;
    release_key();
  endtask

  task automatic stage_b(input logic [N-1:0] b, input logic c);
    int   lat;
    exp_t e;
    e = model_add(int'(model_a), int'(b), int'(c));
    sb.push_back(e);
    last_res = e.res;
    press_start(b, c, lat);
    chk("lat_b", 32'(lat), 32'(LAT));
    chk("state_compute", 32'(bus.State), 32'd2);
    chk("b_captured", 32'(bus.B), 32'(b));
    chk("cin_captured", 32'(bus.Cin), 32'(c));
    @(negedge clk);
    chk("state_show", 32'(bus.State), 32'd3);
    chk("valid_one_after_b", 32'(bus.Valid), 32'd1);
    release_key();
  endtask

  initial begin
    int lat;
    checks     = 0;
    failures   = 0;
    prev_valid = 1'b0;
    model_a    = '0;
    last_res   = '0;
    Resetn     = 1'b0;
    bus.Load_n = 1'b1;
    bus.Data   = '0;
    bus.Cin_sw = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.State), 32'd0);
    chk("rst_a", 32'(bus.A), 32'd0);
    chk("rst_b", 32'(bus.B), 32'd0);
    chk("rst_cin", 32'(bus.Cin), 32'd0);
    chk("rst_result", 32'(bus.Result), 32'd0);
    chk("rst_valid", 32'(bus.Valid), 32'd0);
    chk("rst_overflow", 32'(bus.Overflow), 32'd0);
    Resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Held button: one capture only, even with switches changing meanwhile.
    press_start(4'h3, 1'b0, lat);
    chk("held_lat", 32'(lat), 32'(LAT));
    chk("held_state", 32'(bus.State), 32'd1);
    model_a  = 4'h3;
    bus.Data = 4'hC;
    repeat (1000) @(negedge clk);
    chk("held_state_after", 32'(bus.State), 32'd1);
    chk("held_a_after", 32'(bus.A), 32'h3);
    release_key();
    repeat (10) @(negedge clk);
    chk("release_state", 32'(bus.State), 32'd1);
    stage_b(4'h4, 1'b0);
    chk("basic_result", 32'(bus.Result), 32'h07);

    stage_a(4'h9);
    stage_b(4'h8, 1'b1);
    chk("carry_result", 32'(bus.Result), 32'h12);
    chk("carry_overflow", 32'(bus.Overflow), 32'd1);
    chk("carry_state", 32'(bus.State), 32'd3);

    // Restart from SHOW: result holds until the next COMPUTE.
    stage_a(4'hF);
    chk("restart_result_held", 32'(bus.Result), 32'(last_res));
    stage_b(4'h1, 1'b0);

    // Asynchronous reset mid-SHOW, checked before the next rising edge.
    @(negedge clk);
    #2 Resetn = 1'b0;
    #1;
    chk("async_state", 32'(bus.State), 32'd0);
    chk("async_result", 32'(bus.Result), 32'd0);
    chk("async_valid", 32'(bus.Valid), 32'd0);
    chk("async_a", 32'(bus.A), 32'd0);
    chk("async_b", 32'(bus.B), 32'd0);
    @(negedge clk);
    Resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      stage_a(N'($urandom_range(0, 15)));
      stage_b(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/addern_operand_loader.md
Name: addern_operand_loader

Overview:
- Sequential front end for the Addern demo on DE-series boards.
- Captures operand A and then operand B plus carry-in from the switches, one per pushbutton press.
- Holds A, B and Cin stable on the Addern inputs, then registers the adder's sum and carry-out as a result with a valid flag.
- Sits between the board I/O (KEY/SW) and Addern, and between Addern and the LEDR display.

Parameters:
- N, 4: operand width; must match the Addern instance.
- DB_CYCLES, 500000: debounce stable-time in clocks (10 ms at 50 MHz); used only when the debounce feature is enabled.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- Resetn  input  1  asynchronous active-low reset (KEY[0])
- Load_n  input  1  load pushbutton, active low (KEY[1]), asynchronous to CLOCK_50
- Data  input  N  operand switches (SW[N-1:0])
- Cin_sw  input  1  carry-in switch (SW[9])
- A  output  N  operand A to Addern
- B  output  N  operand B to Addern
- Cin  output  1  carry-in to Addern
- S  input  N  sum from Addern
- Cout  input  1  carry-out from Addern
- Result  output  N+1  registered {Cout,S}
- Valid  output  1  Result holds a completed addition
- Overflow  output  1  registered two's-complement overflow of the displayed result
- State  output  2  current FSM state encoding, for LEDR debug

Behaviour:
- Reset (Resetn low, asynchronous): state WAIT_A; A, B, Cin, Result, Overflow, Valid all 0; synchronizer flops reset to 1 (button released).
- Press detection:
  - Load_n passes through a 2-flop synchronizer, then a history flop.
  - press = history & ~sync (a falling edge), exactly one clock wide.
  - A held button produces a single press. Release produces nothing.
- FSM states: WAIT_A=0, WAIT_B=1, COMPUTE=2, SHOW=3.
  - WAIT_A: on press, A <= Data, Valid <= 0, go to WAIT_B.
  - WAIT_B: on press, B <= Data, Cin <= Cin_sw, go to COMPUTE.
  - COMPUTE, exactly one cycle:
    - Result <= {Cout,S}; Valid <= 1.
    - Overflow <= (A[N-1]==B[N-1]) && (S[N-1]!=A[N-1]).
    - Go to SHOW unconditionally.
    - A press in this cycle is dropped.
  - SHOW: hold all outputs. On press, A <= Data, Valid <= 0, go to WAIT_B. This is the same action as WAIT_A, so a new computation starts without an extra press.
- A, B and Cin change only on the capture edges above. Addern is combinational and settles before COMPUTE samples it.
- Latency:
  - Load_n falling to first sync flop: 1 clock.
  - To press pulse: 3 clocks.
  - Capture at the 4th edge.
  - Result/Valid update on the edge after B is captured.
- Wrap-around: {Cout,S} is N+1 bits, so unsigned sums never truncate (max 2^(N+1)-1).
- Reset mid-operation: returns to WAIT_A immediately and discards partial operands.

Optional Feature:
- Macro: ADDERN_LOADER_DEBOUNCE_EN.
- Defined: the synchronized Load_n must hold a new level for DB_CYCLES consecutive clocks before the debounced level changes. press is derived from the debounced level. Latency grows by DB_CYCLES. Bounce shorter than DB_CYCLES yields no press.
- Undefined: no counter and no debounce; press comes straight from the synchronizer. This is intended for DESim, where inputs do not bounce.

Decomposition:
- Package addern_pkg holds:
  - typedef enum logic [1:0] loader_state_t {WAIT_A, WAIT_B, COMPUTE, SHOW};
  - localparam int ADDERN_N_DEFAULT = 4.
- Sub-module key_edge_detect handles the synchronizer, optional debounce and falling-edge pulse. Inputs: CLOCK_50, Resetn, key_n. Output: press.
- The top FSM and registers stay in addern_operand_loader.

Test Plan:
- Reset: assert Resetn=0 mid-SHOW → State=0, Result=0, Valid=0, A=B=0 asynchronously, before the next clock edge.
- Basic add (N=4): Data=3 then press; Data=4, Cin_sw=0 then press → Result=5'h07, Overflow=0, Valid=1 exactly 1 clock after B capture.
- Carry/overflow: A=4'h9, B=4'h8, Cin_sw=1 → Result=5'h12, Overflow=1, State=3.
- Held button: hold Load_n low 1000 clocks in WAIT_A → exactly one capture, State=1. Release → no further change.
- SHOW restart: in SHOW, Data=4'hF, press → A=4'hF, Valid=0, State=1. Result still holds the prior value until the next COMPUTE.
- Debounce (macro defined, DB_CYCLES=8): toggle Load_n with 3-clock pulses → no press; hold low 8+ clocks → one press, capture at 8+3+1 clocks after the edge.
